// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: counter encodings,
// PC constants and table index/tag width helpers.
package bp_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Tag covers everything above the index and the 2-bit word offset.
  function automatic int tag_w(input int entries);
    return XLEN - $clog2(entries) - 2;
  endfunction

  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_e'(c + 2'd1);
    end else begin
      if (c != SNT) n = ctr_e'(c - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle of the branch predictor. Prediction is
// combinational on if_pc; the ex_* group is a one-cycle strobe (ex_valid,
// no ready) and mispredict/redirect_pc answer it exactly one cycle later.
interface branch_predictor_if;
  import bp_pkg::*;

  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] perf_branches;
  logic [XLEN-1:0] perf_mispred;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, perf_branches, perf_mispred
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, perf_branches, perf_mispred
  );

endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: valid/tag/target per entry, read
// combinationally, written on taken resolves. Ports carry word addresses (pc[31:2]).
module bp_btb
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-3:0] i_rd_wpc,
  output logic            o_hit,
  output logic [XLEN-1:0] o_target,
  input  logic            i_wr_en,
  input  logic [XLEN-3:0] i_wr_wpc,
  input  logic [XLEN-1:0] i_wr_target
);

  localparam int IW = idx_w(ENTRIES);
  localparam int TW = tag_w(ENTRIES);

  logic [ENTRIES-1:0] r_valid;
  logic [TW-1:0]      r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];

  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_wr_idx;
  logic [TW-1:0] w_rd_tag;
  logic [TW-1:0] w_wr_tag;

  assign w_rd_idx = i_rd_wpc[IW-1:0];
  assign w_rd_tag = i_rd_wpc[XLEN-3:IW];
  assign w_wr_idx = i_wr_wpc[IW-1:0];
  assign w_wr_tag = i_wr_wpc[XLEN-3:IW];

  // Only valid bits need reset; tag/target are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx]  <= 1'b1;
      r_tag[w_wr_idx]    <= w_wr_tag;
      r_target[w_wr_idx] <= i_wr_target;
    end
  end

  assign o_hit    = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_target = r_target[w_rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit counter BHT plus direct-mapped BTB, with a
// registered mispredict/redirect path. Define BP_PERF_EN to get perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bus
);

  localparam int BIW = idx_w(BHT_ENTRIES);

  ctr_e            r_bht [BHT_ENTRIES];
  logic            r_mispredict;
  logic [XLEN-1:0] r_redirect_pc;

  logic [BIW-1:0]  w_rd_bidx;
  logic [BIW-1:0]  w_wr_bidx;
  ctr_e            w_rd_ctr;
  logic            w_btb_hit;
  logic [XLEN-1:0] w_btb_target;
  logic            w_pred_taken;
  logic            w_mispred;
  logic [XLEN-1:0] w_fix_pc;

  assign w_rd_bidx = bus.if_pc[BIW+1:2];
  assign w_wr_bidx = bus.ex_pc[BIW+1:2];
  assign w_rd_ctr  = r_bht[w_rd_bidx];

  bp_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_rd_wpc    (bus.if_pc[XLEN-1:2]),
    .o_hit       (w_btb_hit),
    .o_target    (w_btb_target),
    .i_wr_en     (bus.ex_valid && bus.ex_taken),
    .i_wr_wpc    (bus.ex_pc[XLEN-1:2]),
    .i_wr_target (bus.ex_target)
  );

  // Gated by rst so fetch sees fall-through while tables are being cleared.
  assign w_pred_taken = !rst && w_btb_hit && ((w_rd_ctr == WT) || (w_rd_ctr == ST));

  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_taken ? w_btb_target : bus.if_pc + PC_STEP;

  assign w_mispred = bus.ex_valid &&
                     ((bus.ex_taken != bus.ex_pred_taken) ||
                      (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
  assign w_fix_pc  = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= WNT;
    end else if (bus.ex_valid) begin
      r_bht[w_wr_bidx] <= ctr_next(r_bht[w_wr_bidx], bus.ex_taken);
    end
  end

  // redirect_pc is only loaded on a mispredict so it holds between flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispredict  <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      r_mispredict <= w_mispred;
      if (w_mispred) r_redirect_pc <= w_fix_pc;
    end
  end

  assign bus.mispredict  = r_mispredict;
  assign bus.redirect_pc = r_redirect_pc;

`ifdef BP_PERF_EN
  logic [XLEN-1:0] r_perf_branches;
  logic [XLEN-1:0] r_perf_mispred;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_branches <= '0;
      r_perf_mispred  <= '0;
    end else begin
      if (bus.ex_valid) r_perf_branches <= r_perf_branches + 32'd1;
      if (w_mispred)    r_perf_mispred  <= r_perf_mispred + 32'd1;
    end
  end

  assign bus.perf_branches = r_perf_branches;
  assign bus.perf_mispred  = r_perf_mispred;
`else
  assign bus.perf_branches = '0;
  assign bus.perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: vector table for the counter/BTB walk
// at one PC, plus hand sequences for bypass, aliasing, wrap and reset cases.
module tb_branch_predictor;
  import bp_pkg::*;

  localparam int BHT_N = 64;
  localparam int BTB_N = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predictor_if bus();

  branch_predictor #(.BHT_ENTRIES(BHT_N), .BTB_ENTRIES(BTB_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_branches = '0;
  logic [31:0] exp_mispred  = '0;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        ptaken;
    logic [31:0] ptarget;
    logic        exp_mis;
    logic [31:0] exp_redir;
    logic        exp_ptaken;
    logic [31:0] exp_ptarget;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive_ex(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                          input logic ptaken, input logic [31:0] ptarget);
    bus.ex_valid       = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_taken       = taken;
    bus.ex_target      = target;
    bus.ex_pred_taken  = ptaken;
    bus.ex_pred_target = ptarget;
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0;
  endtask

  task automatic check_perf(input string tag);
`ifdef BP_PERF_EN
    check({tag, "_perf_branches"}, bus.perf_branches, exp_branches);
    check({tag, "_perf_mispred"},  bus.perf_mispred,  exp_mispred);
`else
    check({tag, "_perf_branches"}, bus.perf_branches, 32'h0);
    check({tag, "_perf_mispred"},  bus.perf_mispred,  32'h0);
`endif
  endtask

  initial begin
    // Counter walk at 0x100: 01->10->11->11->10->01->00->00, then mixed mispredicts.
    vecs[0] = '{1'b1, 32'h80,  1'b0, 32'h104, 1'b1, 32'h80,  1'b1, 32'h80};
    vecs[1] = '{1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h80,  1'b1, 32'h80};
    vecs[2] = '{1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h80,  1'b1, 32'h80};
    vecs[3] = '{1'b0, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104, 1'b1, 32'h80};
    vecs[4] = '{1'b0, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104, 1'b0, 32'h104};
    vecs[5] = '{1'b0, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104};
    vecs[6] = '{1'b0, 32'h80,  1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 32'h104};
    vecs[7] = '{1'b1, 32'h80,  1'b0, 32'h104, 1'b1, 32'h80,  1'b0, 32'h104};
    vecs[8] = '{1'b1, 32'h80,  1'b1, 32'h90,  1'b1, 32'h80,  1'b1, 32'h80};
    vecs[9] = '{1'b1, 32'h3c0, 1'b1, 32'h80,  1'b1, 32'h3c0, 1'b1, 32'h3c0};

    rst = 1'b1;
    idle();
    bus.ex_pc = '0; bus.ex_taken = 1'b0; bus.ex_target = '0;
    bus.ex_pred_taken = 1'b0; bus.ex_pred_target = '0;
    bus.if_pc = 32'h100;
    step();
    check("rst_hold_pred_taken",  {31'b0, bus.pred_taken}, 32'h0);
    check("rst_hold_pred_target", bus.pred_target, 32'h104);
    step();
    rst = 1'b0;
    check("reset_mispredict",  {31'b0, bus.mispredict}, 32'h0);
    check("reset_redirect_pc", bus.redirect_pc, 32'h0);
    check("reset_pred_taken",  {31'b0, bus.pred_taken}, 32'h0);
    check("reset_pred_target", bus.pred_target, 32'h104);
    check_perf("reset");
    step();
    check("post_reset_mispredict", {31'b0, bus.mispredict}, 32'h0);

    // Back-to-back resolves at 0x100; each row checked the cycle after it.
    for (int i = 0; i < 10; i++) begin
      drive_ex(32'h100, vecs[i].taken, vecs[i].target, vecs[i].ptaken, vecs[i].ptarget);
      bus.if_pc = 32'h100;
      step();
      exp_branches++;
      if (vecs[i].exp_mis) exp_mispred++;
      check($sformatf("vec%0d_mispredict", i), {31'b0, bus.mispredict}, {31'b0, vecs[i].exp_mis});
      check($sformatf("vec%0d_redirect", i), bus.redirect_pc, vecs[i].exp_redir);
      check($sformatf("vec%0d_pred_taken", i), {31'b0, bus.pred_taken}, {31'b0, vecs[i].exp_ptaken});
      check($sformatf("vec%0d_pred_target", i), bus.pred_target, vecs[i].exp_ptarget);
    end
    idle();
    step();
    check("idle_mispredict_drops", {31'b0, bus.mispredict}, 32'h0);
    check("idle_redirect_holds",   bus.redirect_pc, 32'h3c0);
    check_perf("table");

    // Same-cycle resolve at the fetched index sees the old counter (11).
    drive_ex(32'h100, 1'b0, 32'h3c0, 1'b1, 32'h3c0);
    #1;
    check("nobypass_pred_taken",  {31'b0, bus.pred_taken}, 32'h1);
    check("nobypass_pred_target", bus.pred_target, 32'h3c0);
    step();
    exp_branches++; exp_mispred++;
    idle();
    check("nobypass_mispredict", {31'b0, bus.mispredict}, 32'h1);
    check("nobypass_redirect",   bus.redirect_pc, 32'h104);
    check("nobypass_after_pred", {31'b0, bus.pred_taken}, 32'h1);

    // Aliasing: same BTB index, different tag; second also shares the BHT counter.
    bus.if_pc = 32'h100 + 4 * BTB_N;
    #1;
    check("alias_btb_pred_taken",  {31'b0, bus.pred_taken}, 32'h0);
    check("alias_btb_pred_target", bus.pred_target, 32'h144);
    bus.if_pc = 32'h100 + 4 * BHT_N;
    #1;
    check("alias_bht_pred_taken",  {31'b0, bus.pred_taken}, 32'h0);
    check("alias_bht_pred_target", bus.pred_target, 32'h204);
    bus.if_pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_pred_taken",  {31'b0, bus.pred_taken}, 32'h0);
    check("wrap_pred_target", bus.pred_target, 32'h0);

    // Not-taken redirect at the top of the address space wraps to 0.
    step();
    drive_ex(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h80);
    step();
    exp_branches++; exp_mispred++;
    idle();
    check("wrap_mispredict", {31'b0, bus.mispredict}, 32'h1);
    check("wrap_redirect",   bus.redirect_pc, 32'h0);
    step();
    check("wrap_mispredict_drop", {31'b0, bus.mispredict}, 32'h0);
    check_perf("pre_reset");

    // Reset beats a mispredicting resolve; tables stay cleared afterwards.
    rst = 1'b1;
    drive_ex(32'h100, 1'b1, 32'h500, 1'b0, 32'h104);
    bus.if_pc = 32'h100;
    #1;
    check("rst_gate_pred_taken",  {31'b0, bus.pred_taken}, 32'h0);
    check("rst_gate_pred_target", bus.pred_target, 32'h104);
    step();
    exp_branches = '0; exp_mispred = '0;
    check("rst_ex_mispredict", {31'b0, bus.mispredict}, 32'h0);
    check("rst_ex_redirect",   bus.redirect_pc, 32'h0);
    check_perf("rst_ex");
    rst = 1'b0;
    idle();
    step();
    check("rst_ex_after_mispredict", {31'b0, bus.mispredict}, 32'h0);
    check("rst_ex_after_pred_taken", {31'b0, bus.pred_taken}, 32'h0);
    check("rst_ex_after_pred_target", bus.pred_target, 32'h104);

    // One taken resolve after reset: counter 01 -> 10, so prediction turns taken.
    drive_ex(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    step();
    exp_branches++; exp_mispred++;
    idle();
    check("retrain_mispredict",  {31'b0, bus.mispredict}, 32'h1);
    check("retrain_redirect",    bus.redirect_pc, 32'h80);
    check("retrain_pred_taken",  {31'b0, bus.pred_taken}, 32'h1);
    check("retrain_pred_target", bus.pred_target, 32'h80);
    step();
    check_perf("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
